// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per handshake into a UART frame (start, data LSB-first, optional parity, 1/2 stop)
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk2,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done_t
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [2:0]           bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par, par_n, tx_n, done_n, bit_end;
   assign busy = state != IDLE;
   always_ff @(posedge clk2)
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         tx       <= 1'b1;
         done_t   <= 1'b0;
         tx_ready <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par      <= par_n;
         tx       <= tx_n;
         done_t   <= done_n;
         tx_ready <= state_n == IDLE;
      end
   always_comb begin
      bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
      state_n   = state;
      cnt_n     = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par;
      done_n    = 1'b0;
      case (state)
         IDLE:
            if (tx_valid && tx_ready) begin
               shreg_n   = tx_data;
               par_n     = (^tx_data) ^ 1'(PARITY_ODD);
               bit_cnt_n = '0;
               state_n   = START;
            end
         START: if (bit_end) state_n = DATA;
         DATA:
            if (bit_end) begin
               shreg_n   = shreg >> 1;
               bit_cnt_n = bit_cnt == LAST_DATA ? '0 : bit_cnt + 1'b1;
               if (bit_cnt == LAST_DATA) state_n = PARITY_EN != 0 ? PARITY : STOP;
            end
         PARITY: if (bit_end) state_n = STOP;
         STOP:
            if (bit_end) begin
               bit_cnt_n = bit_cnt == LAST_STOP ? '0 : bit_cnt + 1'b1;
               done_n    = bit_cnt == LAST_STOP;
               if (bit_cnt == LAST_STOP) state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
      // tx is registered, so it is driven from the state being entered
      tx_n = state_n == START  ? 1'b0 :
             state_n == DATA   ? shreg_n[0] :
             state_n == PARITY ? par_n : 1'b1;
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame checks across four parameterisations of uart_transmitter
module tb_uart_transmitter;
   logic       clk2 = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] tx_valid = '0;
   logic [7:0] tx_data  = '0;
   logic [3:0] tx_ready, tx, busy, done_t;
   int n_chk  = 0;
   int n_fail = 0;
   int cpb[4] = '{16, 16, 16, 2};
   int nb[4]  = '{8, 8, 8, 5};
   int pen[4] = '{1, 1, 0, 1};
   int pod[4] = '{0, 1, 0, 0};
   int stp[4] = '{1, 1, 2, 1};
   always #5 clk2 = ~clk2;
   uart_transmitter u0 (
      .clk2(clk2), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .tx(tx[0]), .busy(busy[0]), .done_t(done_t[0]));
   uart_transmitter #(.PARITY_ODD(1)) u1 (
      .clk2(clk2), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .tx(tx[1]), .busy(busy[1]), .done_t(done_t[1]));
   uart_transmitter #(.PARITY_EN(0), .STOP_BITS(2)) u2 (
      .clk2(clk2), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .tx(tx[2]), .busy(busy[2]), .done_t(done_t[2]));
   uart_transmitter #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u3 (
      .clk2(clk2), .rst(rst), .tx_data(tx_data[4:0]), .tx_valid(tx_valid[3]),
      .tx_ready(tx_ready[3]), .tx(tx[3]), .busy(busy[3]), .done_t(done_t[3]));
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic exp_bit(int i, int k, logic [7:0] b);
      logic [7:0] m;
      m = b & 8'((1 << nb[i]) - 1);
      if (k == 0) return 1'b0;
      if (k <= nb[i]) return m[k-1];
      if (pen[i] != 0 && k == nb[i] + 1) return (^m) ^ 1'(pod[i]);
      return 1'b1;
   endfunction
   task automatic wait_ready(int i);
      for (int w = 0; w < 50 && tx_ready[i] !== 1'b1; w++) @(negedge clk2);
      check($sformatf("u%0d ready before send", i), tx_ready[i], 1);
   endtask
   task automatic frame(int i, logic [7:0] b, bit hold, bit disturb);
      int f;
      f = (1 + nb[i] + pen[i] + stp[i]) * cpb[i];
      wait_ready(i);
      tx_data     = b;
      tx_valid[i] = 1'b1;
      @(negedge clk2);
      if (!hold) tx_valid[i] = 1'b0;
      for (int c = 0; c <= f; c++) begin
         if (c > 0) @(negedge clk2);
         check($sformatf("u%0d %02h tx c%0d", i, b, c), tx[i], c < f ? exp_bit(i, c / cpb[i], b) : 1'b1);
         check($sformatf("u%0d %02h busy c%0d", i, b, c), busy[i], c < f);
         check($sformatf("u%0d %02h done c%0d", i, b, c), done_t[i], c == f);
         if (disturb && c == 4 * cpb[i]) begin
            tx_data     = ~b;
            tx_valid[i] = 1'b1;
         end
         if (disturb && c == 4 * cpb[i] + 1) tx_valid[i] = 1'b0;
      end
      check($sformatf("u%0d %02h ready at done", i, b), tx_ready[i], 1);
   endtask
   task automatic idle(int i, int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk2);
         check($sformatf("u%0d idle busy c%0d", i, c), busy[i], 0);
         check($sformatf("u%0d idle tx c%0d", i, c), tx[i], 1);
         check($sformatf("u%0d idle done c%0d", i, c), done_t[i], 0);
      end
   endtask
   initial begin
      tx_valid = 4'hF;
      repeat (3) @(negedge clk2);
      check("reset tx", tx, 4'hF);
      check("reset busy", busy, 0);
      check("reset done", done_t, 0);
      check("reset ready", tx_ready, 0);
      tx_valid = '0;
      rst      = 1'b0;
      @(negedge clk2);
      check("ready after reset", tx_ready, 4'hF);
      check("busy after reset", busy, 0);
      frame(0, 8'hA5, 0, 0);
      frame(0, 8'h01, 0, 0);
      frame(1, 8'h01, 0, 0);
      frame(2, 8'h01, 0, 0);
      frame(0, 8'h3C, 1, 0);
      frame(0, 8'hC3, 0, 0);
      idle(0, 40);
      frame(0, 8'h55, 0, 1);
      idle(0, 40);
      wait_ready(0);
      tx_data     = 8'h96;
      tx_valid[0] = 1'b1;
      @(negedge clk2);
      tx_valid[0] = 1'b0;
      repeat (64) @(negedge clk2);
      check("mid-frame busy", busy[0], 1);
      rst         = 1'b1;
      tx_valid[0] = 1'b1;
      @(negedge clk2);
      rst         = 1'b0;
      tx_valid[0] = 1'b0;
      check("abort tx", tx[0], 1);
      check("abort busy", busy[0], 0);
      check("abort done", done_t[0], 0);
      check("abort ready", tx_ready[0], 0);
      @(negedge clk2);
      check("ready after abort", tx_ready[0], 1);
      check("no accept in reset", busy[0], 0);
      check("no done after abort", done_t[0], 0);
      frame(0, 8'h81, 0, 0);
      frame(3, 8'h1F, 0, 0);
      frame(3, 8'hE6, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
